qracc_sram_arbiter: RTL and testbench

//  Shares the single QRAcc SRAM request port (sram_itf slave side) between two requesters:

---
 rtl/qracc_sram_arbiter.sv | 116 +++++++++++
 tb/tb_qracc_sram_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/qracc_sram_arbiter.sv
// Two-requester round-robin arbiter for the QRAcc SRAM request port.
// Grants lock across stalled handshakes; a small ID FIFO steers each read response back to its owner.
module qracc_sram_arbiter #(
    parameter int numRows        = 128,
    parameter int numCols        = 32,
    parameter int maxOutstanding = 4,
    localparam int addrBits      = $clog2(numRows)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            rq_wr_i,
    input  logic [1:0]            rq_valid_i,
    output logic [1:0]            rq_ready_o,
    input  logic [2*numCols-1:0]  wr_data_i,
    input  logic [2*addrBits-1:0] addr_i,
    output logic [1:0]            rd_valid_o,
    output logic [numCols-1:0]    rd_data_o,
    output logic                  sram_rq_wr_o,
    output logic                  sram_rq_valid_o,
    input  logic                  sram_rq_ready_i,
    output logic [numCols-1:0]    sram_wr_data_o,
    output logic [addrBits-1:0]   sram_addr_o,
    input  logic                  sram_rd_valid_i,
    input  logic [numCols-1:0]    sram_rd_data_i,
    output logic                  err_o
);

    localparam int idxBits = $clog2(maxOutstanding);
    localparam int ptrBits = idxBits + 1;

    logic               prio_q;
    logic               lock_q;
    logic               gnt_q;
    logic               err_q;
    logic [ptrBits-1:0] wr_ptr;
    logic [ptrBits-1:0] rd_ptr;
    logic               id_mem [maxOutstanding];

    logic                grant;
    logic                sel_wr;
    logic [addrBits-1:0] sel_addr;
    logic [numCols-1:0]  sel_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fire;
    logic                push;
    logic                pop;
    logic                head;

    always_comb begin
        grant = 1'b0;
        if (lock_q)
            grant = gnt_q;
        else if (&rq_valid_i)
            grant = prio_q;
        else
            grant = rq_valid_i[1];

        sel_wr   = grant ? rq_wr_i[1] : rq_wr_i[0];
        sel_addr = grant ? addr_i[2*addrBits-1:addrBits] : addr_i[addrBits-1:0];
        sel_data = grant ? wr_data_i[2*numCols-1:numCols] : wr_data_i[numCols-1:0];

        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[ptrBits-1] != rd_ptr[ptrBits-1]) &&
                     (wr_ptr[idxBits-1:0] == rd_ptr[idxBits-1:0]);

        // A full ID FIFO only holds back reads; writes never produce a response.
        sram_rq_valid_o = (grant ? rq_valid_i[1] : rq_valid_i[0]) & (sel_wr | ~fifo_full);
        sram_rq_wr_o    = sram_rq_valid_o & sel_wr;
        sram_addr_o     = sram_rq_valid_o ? sel_addr : '0;
        sram_wr_data_o  = sram_rq_valid_o ? sel_data : '0;

        fire       = sram_rq_valid_o & sram_rq_ready_i;
        push       = fire & ~sel_wr;
        rq_ready_o = fire ? (grant ? 2'b10 : 2'b01) : 2'b00;

        head       = id_mem[rd_ptr[idxBits-1:0]];
        pop        = sram_rd_valid_i & ~fifo_empty;
        rd_valid_o = pop ? (head ? 2'b10 : 2'b01) : 2'b00;
        rd_data_o  = pop ? sram_rd_data_i : '0;

        err_o = err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
            lock_q <= 1'b0;
            gnt_q  <= 1'b0;
            err_q  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fire) begin
                prio_q <= ~grant;
                lock_q <= 1'b0;
            end else if (sram_rq_valid_o) begin
                lock_q <= 1'b1;
                gnt_q  <= grant;
            end
            if (push)
                wr_ptr <= wr_ptr + ptrBits'(1);
            if (pop)
                rd_ptr <= rd_ptr + ptrBits'(1);
            if (sram_rd_valid_i && fifo_empty)
                err_q <= 1'b1;
        end
    end

    // ID storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push)
            id_mem[wr_ptr[idxBits-1:0]] <= grant;
    end

endmodule

// File: tb/tb_qracc_sram_arbiter.sv
// Directed bench for qracc_sram_arbiter: grant order, lock, read routing, FIFO full, error flag.
module tb_qracc_sram_arbiter;

    localparam int numCols  = 32;
    localparam int addrBits = 7;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            rq_wr_i;
    logic [1:0]            rq_valid_i;
    logic [1:0]            rq_ready_o;
    logic [2*numCols-1:0]  wr_data_i;
    logic [2*addrBits-1:0] addr_i;
    logic [1:0]            rd_valid_o;
    logic [numCols-1:0]    rd_data_o;
    logic                  sram_rq_wr_o;
    logic                  sram_rq_valid_o;
    logic                  sram_rq_ready_i;
    logic [numCols-1:0]    sram_wr_data_o;
    logic [addrBits-1:0]   sram_addr_o;
    logic                  sram_rd_valid_i;
    logic [numCols-1:0]    sram_rd_data_i;
    logic                  err_o;

    int total = 0;
    int bad   = 0;

    qracc_sram_arbiter dut (
        .clk(clk), .rst(rst),
        .rq_wr_i(rq_wr_i), .rq_valid_i(rq_valid_i), .rq_ready_o(rq_ready_o),
        .wr_data_i(wr_data_i), .addr_i(addr_i),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
        .sram_rq_wr_o(sram_rq_wr_o), .sram_rq_valid_o(sram_rq_valid_o),
        .sram_rq_ready_i(sram_rq_ready_i), .sram_wr_data_o(sram_wr_data_o),
        .sram_addr_o(sram_addr_o), .sram_rd_valid_i(sram_rd_valid_i),
        .sram_rd_data_i(sram_rd_data_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled 4ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] v, input logic [1:0] w,
                           input logic [6:0] a0, input logic [6:0] a1);
        rq_valid_i = v;
        rq_wr_i    = w;
        addr_i     = {a1, a0};
        wr_data_i  = {25'h0, a1, 25'h0, a0} | 64'hD000_0000_C000_0000;
    endtask

    function automatic logic [31:0] wdata(input logic r, input logic [6:0] a);
        return (r ? 32'hD000_0000 : 32'hC000_0000) | {25'h0, a};
    endfunction

    initial begin
        // 1: reset with random inputs
        rst             = 1'b1;
        rq_wr_i         = 2'($urandom);
        rq_valid_i      = 2'($urandom);
        wr_data_i       = {$urandom, $urandom};
        addr_i          = 14'($urandom);
        sram_rq_ready_i = 1'($urandom);
        sram_rd_valid_i = 1'b1;
        sram_rd_data_i  = $urandom;
        #13;
        check("rst_rd_valid", 64'(rd_valid_o), 64'h0);
        check("rst_err", 64'(err_o), 64'h0);
        set_req(2'b00, 2'b00, 7'd0, 7'd0);
        sram_rq_ready_i = 1'b0;
        sram_rd_valid_i = 1'b0;
        sram_rd_data_i  = '0;
        next_cycle();
        rst = 1'b0;
        #4;
        check("idle_valid", 64'(sram_rq_valid_o), 64'h0);
        check("idle_rd_data", 64'(rd_data_o), 64'h0);

        // 2: both write, ready=1 -> 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            set_req(2'b11, 2'b11, 7'(10 + k), 7'(20 + k));
            sram_rq_ready_i = 1'b1;
            #4;
            check($sformatf("rr_ready_%0d", k), 64'(rq_ready_o), (k % 2) ? 64'h2 : 64'h1);
            check($sformatf("rr_addr_%0d", k), 64'(sram_addr_o), (k % 2) ? 64'(20 + k) : 64'(10 + k));
            check($sformatf("rr_data_%0d", k), 64'(sram_wr_data_o),
                  64'(wdata(1'(k % 2), (k % 2) ? 7'(20 + k) : 7'(10 + k))));
            check($sformatf("rr_wr_%0d", k), 64'(sram_rq_wr_o), 64'h1);
        end

        // single req0 write so that prio points at req1
        next_cycle();
        set_req(2'b01, 2'b11, 7'd1, 7'd0);
        #4;
        check("pre_ready", 64'(rq_ready_o), 64'h1);

        // 3: req0 stalled, req1 arrives, grant stays locked on 0
        next_cycle();
        set_req(2'b01, 2'b11, 7'h11, 7'h22);
        sram_rq_ready_i = 1'b0;
        #4;
        check("lock_c1_valid", 64'(sram_rq_valid_o), 64'h1);
        check("lock_c1_ready", 64'(rq_ready_o), 64'h0);
        for (int k = 2; k <= 3; k++) begin
            next_cycle();
            set_req(2'b11, 2'b11, 7'h11, 7'h22);
            #4;
            check($sformatf("lock_c%0d_addr", k), 64'(sram_addr_o), 64'h11);
        end
        next_cycle();
        sram_rq_ready_i = 1'b1;
        #4;
        check("lock_hs_ready", 64'(rq_ready_o), 64'h1);
        check("lock_hs_addr", 64'(sram_addr_o), 64'h11);
        next_cycle();
        set_req(2'b10, 2'b11, 7'h11, 7'h22);
        #4;
        check("lock_after_ready", 64'(rq_ready_o), 64'h2);
        check("lock_after_addr", 64'(sram_addr_o), 64'h22);

        // 4: reads routed back by owner
        next_cycle();
        set_req(2'b11, 2'b00, 7'd5, 7'd9);
        #4;
        check("rd0_ready", 64'(rq_ready_o), 64'h1);
        check("rd0_addr", 64'(sram_addr_o), 64'd5);
        check("rd0_wr", 64'(sram_rq_wr_o), 64'h0);
        next_cycle();
        #4;
        check("rd1_ready", 64'(rq_ready_o), 64'h2);
        check("rd1_addr", 64'(sram_addr_o), 64'd9);
        next_cycle();
        set_req(2'b00, 2'b00, 7'd0, 7'd0);
        sram_rd_valid_i = 1'b1;
        sram_rd_data_i  = 32'hAAAA_0005;
        #4;
        check("resp0_valid", 64'(rd_valid_o), 64'h1);
        check("resp0_data", 64'(rd_data_o), 64'hAAAA_0005);
        next_cycle();
        sram_rd_data_i = 32'hBBBB_0009;
        #4;
        check("resp1_valid", 64'(rd_valid_o), 64'h2);
        check("resp1_data", 64'(rd_data_o), 64'hBBBB_0009);
        next_cycle();
        sram_rd_valid_i = 1'b0;
        #4;
        check("resp_idle_valid", 64'(rd_valid_o), 64'h0);
        check("resp_idle_data", 64'(rd_data_o), 64'h0);
        check("resp_err", 64'(err_o), 64'h0);

        // 5: fill the ID FIFO, write passes while read stalls until a pop
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            set_req(2'b11, 2'b00, 7'd1, 7'd2);
            #4;
            check($sformatf("fill_ready_%0d", k), 64'(rq_ready_o), (k % 2) ? 64'h2 : 64'h1);
        end
        next_cycle();
        set_req(2'b11, 2'b01, 7'h30, 7'h31);
        #4;
        check("full_wr_ready", 64'(rq_ready_o), 64'h1);
        check("full_wr_wr", 64'(sram_rq_wr_o), 64'h1);
        next_cycle();
        set_req(2'b10, 2'b00, 7'h30, 7'h31);
        #4;
        check("full_rd_valid", 64'(sram_rq_valid_o), 64'h0);
        check("full_rd_ready", 64'(rq_ready_o), 64'h0);
        next_cycle();
        sram_rd_valid_i = 1'b1;
        sram_rd_data_i  = 32'h1;
        #4;
        check("full_pop_rd", 64'(rd_valid_o), 64'h1);
        check("full_pop_ready", 64'(rq_ready_o), 64'h0);
        next_cycle();
        sram_rd_valid_i = 1'b0;
        #4;
        check("unfull_ready", 64'(rq_ready_o), 64'h2);
        check("unfull_addr", 64'(sram_addr_o), 64'h31);
        next_cycle();
        set_req(2'b00, 2'b00, 7'd0, 7'd0);
        sram_rd_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sram_rd_data_i = 32'(100 + k);
            #4;
            check($sformatf("drain_owner_%0d", k), 64'(rd_valid_o), (k == 1) ? 64'h1 : 64'h2);
            check($sformatf("drain_data_%0d", k), 64'(rd_data_o), 64'(100 + k));
            next_cycle();
        end

        // 6: response with nothing outstanding sets a sticky error
        #4;
        check("orphan_rd_valid", 64'(rd_valid_o), 64'h0);
        check("orphan_err_same", 64'(err_o), 64'h0);
        next_cycle();
        sram_rd_valid_i = 1'b0;
        #4;
        check("orphan_err_next", 64'(err_o), 64'h1);
        repeat (3) next_cycle();
        #4;
        check("orphan_err_held", 64'(err_o), 64'h1);
        next_cycle();
        rst = 1'b1;
        #2;
        check("orphan_err_rst", 64'(err_o), 64'h0);
        next_cycle();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
